cop_req_buf: RTL and testbench

- Buffers the coprocessor interface between the host CPU and the gnpu reservation station.
- Request path: a DEPTH-entry FIFO carries instruction word plus rs1/rs2/rs3 operands from the CPU to the reservation station, so the CPU does not stall while the station is busy issuing to the systolic array.
- Response path: a 2-entry skid buffer carries result data from the reservation station back to the CPU.
- Both directions use valid/ready handshakes with no combinational ready path through the block.

---
 rtl/cop_req_buf.sv | 134 +++++++++++++
 tb/tb_cop_req_buf.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cop_req_buf.sv
// CPU->RS request FIFO (DEPTH entries, FWFT, >=1 cycle latency) and RS->CPU 2-entry response skid (1 cycle).
// Ready outputs are decoded only from registered counts, so a full buffer refuses a push even while popping.
`ifndef COP_INST_WIDTH
`define COP_INST_WIDTH 32
`endif
`ifndef COP_REG_WIDTH
`define COP_REG_WIDTH 64
`endif

module cop_req_buf #(
    parameter int DEPTH  = 4,
    parameter int INSN_W = `COP_INST_WIDTH,
    parameter int REG_W  = `COP_REG_WIDTH,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_tpu_req_vld_i,
    output logic              cpu_tpu_req_rdy_o,
    input  logic [INSN_W-1:0] cpu_tpu_req_insn_i,
    input  logic [REG_W-1:0]  cpu_tpu_req_rs1_data_i,
    input  logic [REG_W-1:0]  cpu_tpu_req_rs2_data_i,
    input  logic [REG_W-1:0]  cpu_tpu_req_rs3_data_i,
    output logic              rs_req_vld_o,
    input  logic              rs_req_rdy_i,
    output logic [INSN_W-1:0] rs_req_insn_o,
    output logic [REG_W-1:0]  rs_req_rs1_data_o,
    output logic [REG_W-1:0]  rs_req_rs2_data_o,
    output logic [REG_W-1:0]  rs_req_rs3_data_o,
    input  logic              rs_resp_vld_i,
    output logic              rs_resp_rdy_o,
    input  logic [REG_W-1:0]  rs_resp_data_i,
    output logic              cpu_tpu_resp_vld_o,
    input  logic              cpu_tpu_resp_rdy_i,
    output logic [REG_W-1:0]  cpu_tpu_resp_data_o,
    output logic [CNT_W-1:0]  req_occupancy_o
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [INSN_W-1:0] insn;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rs3;
    } req_t;

    req_t             mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             req_push, req_pop;
    req_t             req_in, req_head;

    logic [REG_W-1:0] resp_mem_q [2];
    logic             resp_wr_q, resp_wr_d, resp_rd_q, resp_rd_d;
    logic [1:0]       resp_cnt_q, resp_cnt_d;
    logic             resp_push, resp_pop;

    assign cpu_tpu_req_rdy_o = (count_q != CNT_W'(DEPTH));
    assign rs_req_vld_o      = (count_q != '0);
    assign req_push          = cpu_tpu_req_vld_i && cpu_tpu_req_rdy_o;
    assign req_pop           = rs_req_vld_o && rs_req_rdy_i;
    assign req_in            = {cpu_tpu_req_insn_i, cpu_tpu_req_rs1_data_i,
                                cpu_tpu_req_rs2_data_i, cpu_tpu_req_rs3_data_i};
    assign req_head          = mem_q[rd_ptr_q];
    assign req_occupancy_o   = count_q;

    assign rs_req_insn_o     = rs_req_vld_o ? req_head.insn : '0;
    assign rs_req_rs1_data_o = rs_req_vld_o ? req_head.rs1  : '0;
    assign rs_req_rs2_data_o = rs_req_vld_o ? req_head.rs2  : '0;
    assign rs_req_rs3_data_o = rs_req_vld_o ? req_head.rs3  : '0;

    // Pointers wrap on an explicit compare so DEPTH need not be a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (req_push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (req_pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        case ({req_push, req_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_push) mem_q[wr_ptr_q] <= req_in;
    end

    assign rs_resp_rdy_o       = (resp_cnt_q != 2'd2);
    assign cpu_tpu_resp_vld_o  = (resp_cnt_q != 2'd0);
    assign resp_push           = rs_resp_vld_i && rs_resp_rdy_o;
    assign resp_pop            = cpu_tpu_resp_vld_o && cpu_tpu_resp_rdy_i;
    assign cpu_tpu_resp_data_o = cpu_tpu_resp_vld_o ? resp_mem_q[resp_rd_q] : '0;

    always_comb begin
        resp_wr_d  = resp_push ? ~resp_wr_q : resp_wr_q;
        resp_rd_d  = resp_pop  ? ~resp_rd_q : resp_rd_q;
        resp_cnt_d = resp_cnt_q;
        case ({resp_push, resp_pop})
            2'b10:   resp_cnt_d = resp_cnt_q + 1'b1;
            2'b01:   resp_cnt_d = resp_cnt_q - 1'b1;
            default: resp_cnt_d = resp_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_wr_q  <= 1'b0;
            resp_rd_q  <= 1'b0;
            resp_cnt_q <= 2'd0;
        end else begin
            resp_wr_q  <= resp_wr_d;
            resp_rd_q  <= resp_rd_d;
            resp_cnt_q <= resp_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (resp_push) resp_mem_q[resp_wr_q] <= rs_resp_data_i;
    end
endmodule

// File: tb/tb_cop_req_buf.sv
// Scoreboard bench for cop_req_buf: drivers queue expected entries on acceptance, a negedge monitor pops and compares.
module tb_cop_req_buf;
    localparam int DEPTH = 4, INSN_W = 32, REG_W = 64, CNT_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cpu_tpu_req_vld_i, cpu_tpu_req_rdy_o;
    logic [INSN_W-1:0] cpu_tpu_req_insn_i;
    logic [REG_W-1:0]  cpu_tpu_req_rs1_data_i, cpu_tpu_req_rs2_data_i, cpu_tpu_req_rs3_data_i;
    logic              rs_req_vld_o, rs_req_rdy_i;
    logic [INSN_W-1:0] rs_req_insn_o;
    logic [REG_W-1:0]  rs_req_rs1_data_o, rs_req_rs2_data_o, rs_req_rs3_data_o;
    logic              rs_resp_vld_i, rs_resp_rdy_o;
    logic [REG_W-1:0]  rs_resp_data_i;
    logic              cpu_tpu_resp_vld_o, cpu_tpu_resp_rdy_i;
    logic [REG_W-1:0]  cpu_tpu_resp_data_o;
    logic [CNT_W-1:0]  req_occupancy_o;

    always #5 clk = ~clk;

    cop_req_buf #(.DEPTH(DEPTH), .INSN_W(INSN_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_tpu_req_vld_i(cpu_tpu_req_vld_i), .cpu_tpu_req_rdy_o(cpu_tpu_req_rdy_o),
        .cpu_tpu_req_insn_i(cpu_tpu_req_insn_i),
        .cpu_tpu_req_rs1_data_i(cpu_tpu_req_rs1_data_i),
        .cpu_tpu_req_rs2_data_i(cpu_tpu_req_rs2_data_i),
        .cpu_tpu_req_rs3_data_i(cpu_tpu_req_rs3_data_i),
        .rs_req_vld_o(rs_req_vld_o), .rs_req_rdy_i(rs_req_rdy_i),
        .rs_req_insn_o(rs_req_insn_o),
        .rs_req_rs1_data_o(rs_req_rs1_data_o),
        .rs_req_rs2_data_o(rs_req_rs2_data_o),
        .rs_req_rs3_data_o(rs_req_rs3_data_o),
        .rs_resp_vld_i(rs_resp_vld_i), .rs_resp_rdy_o(rs_resp_rdy_o),
        .rs_resp_data_i(rs_resp_data_i),
        .cpu_tpu_resp_vld_o(cpu_tpu_resp_vld_o), .cpu_tpu_resp_rdy_i(cpu_tpu_resp_rdy_i),
        .cpu_tpu_resp_data_o(cpu_tpu_resp_data_o),
        .req_occupancy_o(req_occupancy_o)
    );

    typedef struct {
        logic [31:0] insn;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [63:0] rs3;
        int          stamp;
    } exp_req_t;

    exp_req_t    exp_req[$];
    logic [63:0] exp_resp[$];
    int          resp_pop_cyc[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          stream_mode = 1'b0;
    bit          wrap_done = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen at the negedge completes at the following posedge.
    always @(negedge clk) begin
        exp_req_t e;
        logic [63:0] r;
        if (!rs_req_vld_o)
            chk("req_gate", {32'b0, rs_req_insn_o} | rs_req_rs1_data_o | rs_req_rs2_data_o | rs_req_rs3_data_o, 64'd0);
        if (!cpu_tpu_resp_vld_o)
            chk("resp_gate", cpu_tpu_resp_data_o, 64'd0);
        if (rst_n && rs_req_vld_o && rs_req_rdy_i) begin
            if (exp_req.size() == 0) begin
                chk("req_unexpected", 64'(rs_req_insn_o), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_req.pop_front();
                chk("req_insn", 64'(rs_req_insn_o), 64'(e.insn));
                chk("req_rs1", rs_req_rs1_data_o, e.rs1);
                chk("req_rs2", rs_req_rs2_data_o, e.rs2);
                chk("req_rs3", rs_req_rs3_data_o, e.rs3);
                if (stream_mode) chk("req_latency", 64'(cyc), 64'(e.stamp + 1));
            end
        end
        if (rst_n && cpu_tpu_resp_vld_o && cpu_tpu_resp_rdy_i) begin
            if (exp_resp.size() == 0) begin
                chk("resp_unexpected", cpu_tpu_resp_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                r = exp_resp.pop_front();
                chk("resp_data", cpu_tpu_resp_data_o, r);
                resp_pop_cyc.push_back(cyc);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_req(input logic [31:0] insn, input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] c, output int acc);
        int n = 0;
        acc = -1;
        cpu_tpu_req_vld_i      = 1'b1;
        cpu_tpu_req_insn_i     = insn;
        cpu_tpu_req_rs1_data_i = a;
        cpu_tpu_req_rs2_data_i = b;
        cpu_tpu_req_rs3_data_i = c;
        while (acc < 0 && n < 200) begin
            @(negedge clk);
            if (cpu_tpu_req_rdy_o) begin
                exp_req.push_back('{insn, a, b, c, cyc});
                acc = cyc;
            end
            @(posedge clk); #1;
            n++;
        end
        cpu_tpu_req_vld_i = 1'b0;
        if (acc < 0) chk("req_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_resp(input logic [63:0] d);
        int  n = 0;
        bit  done = 1'b0;
        rs_resp_vld_i  = 1'b1;
        rs_resp_data_i = d;
        while (!done && n < 200) begin
            @(negedge clk);
            if (rs_resp_rdy_o) begin
                exp_resp.push_back(d);
                done = 1'b1;
            end
            @(posedge clk); #1;
            n++;
        end
        rs_resp_vld_i = 1'b0;
        if (!done) chk("resp_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_req.size() != 0 || exp_resp.size() != 0) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_req", 64'(exp_req.size()), 64'd0);
        chk("drain_resp", 64'(exp_resp.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int c0;
        rst_n = 1'b0;
        cpu_tpu_req_vld_i = 1'b1;
        cpu_tpu_req_insn_i = 32'hDEAD_BEEF;
        cpu_tpu_req_rs1_data_i = 64'h11;
        cpu_tpu_req_rs2_data_i = 64'h22;
        cpu_tpu_req_rs3_data_i = 64'h33;
        rs_req_rdy_i = 1'b0;
        rs_resp_vld_i = 1'b0;
        rs_resp_data_i = '0;
        cpu_tpu_resp_rdy_i = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cpu_tpu_req_vld_i = 1'b0;
        @(negedge clk);
        chk("rst_req_rdy", 64'(cpu_tpu_req_rdy_o), 64'd1);
        chk("rst_req_vld", 64'(rs_req_vld_o), 64'd0);
        chk("rst_occ", 64'(req_occupancy_o), 64'd0);
        chk("rst_resp_rdy", 64'(rs_resp_rdy_o), 64'd1);
        chk("rst_resp_vld", 64'(cpu_tpu_resp_vld_o), 64'd0);
        @(posedge clk); #1;

        // Fill to DEPTH with the station stalled, then hold a fifth request.
        for (int i = 1; i <= 4; i++)
            send_req(32'(i), 64'(i) << 8, 64'(i) << 16, 64'(i) << 24, acc);
        @(negedge clk);
        chk("full_rdy", 64'(cpu_tpu_req_rdy_o), 64'd0);
        chk("full_occ", 64'(req_occupancy_o), 64'd4);
        @(posedge clk); #1;
        c0 = 0;
        fork
            send_req(32'h5, 64'h500, 64'h5_0000, 64'h500_0000, acc);
            begin
                repeat (2) begin
                    @(negedge clk);
                    chk("full_hold", 64'(cpu_tpu_req_rdy_o), 64'd0);
                end
                @(posedge clk); #1;
                c0 = cyc;
                rs_req_rdy_i = 1'b1;
            end
        join
        chk("fifth_accept_cycle", 64'(acc), 64'(c0 + 1));
        wait_drain();

        // Streaming with both sides ready.
        stream_mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send_req(32'h1000 + 32'(i), 64'(i), ~64'(i), 64'(i * 3), acc);
            chk("stream_vld", 64'(rs_req_vld_o), 64'd1);
            chk("stream_occ", 64'(req_occupancy_o), 64'd1);
        end
        wait_drain();
        stream_mode = 1'b0;

        // Random stalls on both sides across several pointer wraps.
        wrap_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 11; i++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        @(posedge clk); #1;
                    end
                    send_req(32'h200 + 32'(i), 64'hA0 + 64'(i), 64'hB0 + 64'(i), 64'hC0 + 64'(i), acc);
                end
                wrap_done = 1'b1;
            end
            begin
                while (!wrap_done) begin
                    rs_req_rdy_i = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        rs_req_rdy_i = 1'b1;
        wait_drain();

        // Response skid: fill both entries, then release.
        cpu_tpu_resp_rdy_i = 1'b0;
        send_resp(64'hAAAA);
        send_resp(64'hBBBB);
        @(negedge clk);
        chk("skid_full_rdy", 64'(rs_resp_rdy_o), 64'd0);
        chk("skid_head", cpu_tpu_resp_data_o, 64'hAAAA);
        @(posedge clk); #1;
        resp_pop_cyc.delete();
        cpu_tpu_resp_rdy_i = 1'b1;
        wait_drain();
        chk("skid_pops", 64'(resp_pop_cyc.size()), 64'd2);
        if (resp_pop_cyc.size() == 2)
            chk("skid_consecutive", 64'(resp_pop_cyc[1] - resp_pop_cyc[0]), 64'd1);

        // Response streaming throughput.
        resp_pop_cyc.delete();
        send_resp(64'h1111);
        send_resp(64'h2222);
        send_resp(64'h3333);
        wait_drain();
        chk("resp_stream_pops", 64'(resp_pop_cyc.size()), 64'd3);
        if (resp_pop_cyc.size() == 3)
            chk("resp_stream_rate", 64'(resp_pop_cyc[2] - resp_pop_cyc[0]), 64'd2);

        // Reset with traffic buffered in both directions.
        rs_req_rdy_i = 1'b0;
        cpu_tpu_resp_rdy_i = 1'b0;
        for (int i = 0; i < 3; i++)
            send_req(32'hBAD0 + 32'(i), 64'hDEAD, 64'hDEAD, 64'hDEAD, acc);
        send_resp(64'hDEAD);
        @(negedge clk);
        chk("pre_rst_occ", 64'(req_occupancy_o), 64'd3);
        chk("pre_rst_resp_vld", 64'(cpu_tpu_resp_vld_o), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_req.delete();
        exp_resp.delete();
        @(posedge clk); #1;
        chk("mid_rst_req_vld", 64'(rs_req_vld_o), 64'd0);
        chk("mid_rst_occ", 64'(req_occupancy_o), 64'd0);
        chk("mid_rst_resp_vld", 64'(cpu_tpu_resp_vld_o), 64'd0);
        chk("mid_rst_req_rdy", 64'(cpu_tpu_req_rdy_o), 64'd1);
        rst_n = 1'b1;
        rs_req_rdy_i = 1'b1;
        cpu_tpu_resp_rdy_i = 1'b1;
        send_req(32'h600, 64'h61, 64'h62, 64'h63, acc);
        send_req(32'h700, 64'h71, 64'h72, 64'h73, acc);
        send_resp(64'h5555);
        wait_drain();
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle_occ", 64'(req_occupancy_o), 64'd0);
        chk("post_rst_idle_resp", 64'(cpu_tpu_resp_vld_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
